// File: rtl/inverse_factorial_blk_if.sv
// inverse_factorial_blk_if: request/result handshake between a requester and the inverse factorial block.
interface inverse_factorial_blk_if #(
    parameter int DATA_W = 46,
    parameter int N_W    = 4
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic [N_W-1:0]    out_data;
    logic              out_exact;
    logic              out_ovf;
    logic              out_valid;
    logic              out_busy;

    modport master (
        output in_data, in_valid,
        input  out_data, out_exact, out_ovf, out_valid, out_busy
    );

    modport slave (
        input  in_data, in_valid,
        output out_data, out_exact, out_ovf, out_valid, out_busy
    );
endinterface

// File: rtl/inverse_factorial_blk.sv
// inverse_factorial_blk: finds the largest n with n! <= V by walking k! upward, flags exact hits and saturation.
module inverse_factorial_blk #(
    parameter int DATA_W = 46,
    parameter int N_W    = 4,
    parameter int MAX_N  = 15
) (
    input logic                  clk,
    input logic                  resetn,
    inverse_factorial_blk_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [N_W-1:0] MAX_K = N_W'(MAX_N);

    state_t            r_state, w_next;
    logic [DATA_W-1:0] r_acc, r_target;
    logic [N_W-1:0]    r_k, r_data, w_res, w_k1;
    logic              r_exact, r_ovf;
    logic              w_start, w_zero, w_eq, w_gt, w_term, w_calc;

    always_comb begin
        w_calc  = r_state == CALC;
        w_start = bus.in_valid && !w_calc;
        w_zero  = r_target == '0;
        w_eq    = r_acc == r_target;
        w_gt    = r_acc > r_target;
        w_term  = w_zero || w_eq || w_gt || r_k == MAX_K;
        w_k1    = r_k + 1'b1;
        w_res   = w_zero ? '0 : w_eq ? r_k : w_gt ? r_k - 1'b1 : MAX_K;
        w_next  = w_start ? CALC : w_calc ? (w_term ? DONE : CALC) : IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The search stops once acc reaches the target or k hits MAX_N, so the truncated product never loses bits.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_acc    <= '0;
            r_k      <= '0;
            r_target <= '0;
            r_data   <= '0;
            r_exact  <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_start) begin
            r_target <= bus.in_data;
            r_acc    <= DATA_W'(1);
            r_k      <= '0;
        end else if (w_calc && w_term) begin
            r_data  <= w_res;
            r_exact <= !w_zero && w_eq;
            r_ovf   <= !w_zero && !w_eq && !w_gt;
        end else if (w_calc) begin
            r_acc <= DATA_W'((DATA_W + N_W)'(r_acc) * (DATA_W + N_W)'(w_k1));
            r_k   <= w_k1;
        end
    end

    assign bus.out_data  = r_data;
    assign bus.out_exact = r_exact;
    assign bus.out_ovf   = r_ovf;
    assign bus.out_valid = r_state == DONE;
    assign bus.out_busy  = w_calc;
endmodule

// File: tb/tb_inverse_factorial_blk.sv
// tb_inverse_factorial_blk: directed corner cases plus random values checked against an arithmetic inverse-factorial model.
module tb_inverse_factorial_blk;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    logic [3:0] last_n;

    always #5 clk = ~clk;

    inverse_factorial_blk_if #(.DATA_W(46), .N_W(4)) bus ();

    inverse_factorial_blk #(.DATA_W(46), .N_W(4), .MAX_N(15)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned fact(input int n);
        longint unsigned f = 1;
        for (int i = 2; i <= n; i++) f *= longint'(i);
        return f;
    endfunction

    // Smallest k with k! >= V decides the answer; V above 15! saturates at 15.
    function automatic void model(input longint unsigned v, output int n, output bit ex,
                                  output bit ov, output int lat);
        n = 15; ex = 0; ov = 1; lat = 16;
        if (v == 0) begin
            n = 0; ov = 0; lat = 1;
            return;
        end
        for (int k = 0; k <= 15; k++) begin
            if (fact(k) >= v) begin
                ex  = fact(k) == v;
                n   = ex ? k : k - 1;
                ov  = 0;
                lat = k + 1;
                return;
            end
        end
    endfunction

    task automatic req(input longint unsigned v);
        bus.in_data  = v[45:0];
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        chk("busy_after_accept", bus.out_busy, 1);
    endtask

    task automatic expect_res(input longint unsigned v, input int pre);
        int n, lat, got;
        bit ex, ov;
        model(v, n, ex, ov, lat);
        got = pre;
        for (int c = 0; c < 40 && !bus.out_valid; c++) begin
            @(posedge clk);
            #1 got++;
        end
        chk("valid_seen", bus.out_valid, 1);
        chk("latency", longint'(got), longint'(lat));
        chk("out_data", bus.out_data, longint'(n));
        chk("out_exact", bus.out_exact, ex);
        chk("out_ovf", bus.out_ovf, ov);
        chk("busy_in_done", bus.out_busy, 0);
        last_n = bus.out_data;
    endtask

    task automatic run(input longint unsigned v);
        req(v);
        expect_res(v, 0);
    endtask

    initial begin
        int seen;
        longint unsigned v;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", bus.out_data, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_busy", bus.out_busy, 0);
        chk("rst_flags", {bus.out_exact, bus.out_ovf}, 0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        run(6);
        run(120);
        run(100);
        run(1);
        run(0);
        run(2);
        run(fact(15));
        run(64'd1 << 45);
        run(fact(15) + 1);
        req(720);
        bus.in_data  = 46'd24;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        expect_res(720, 1);
        seen = 0;
        repeat (10) begin
            @(posedge clk);
            #1 seen += int'(bus.out_valid);
        end
        chk("no_queued_result", seen, 0);
        chk("hold_after_idle", bus.out_data, 6);
        req(5040);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        chk("midrst_data", bus.out_data, 0);
        chk("midrst_exact", bus.out_exact, 0);
        chk("midrst_busy", bus.out_busy, 0);
        chk("midrst_valid", bus.out_valid, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        run(5040);
        for (int n = 0; n <= 15; n++) run(fact(n));
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: v = fact($urandom_range(0, 15)) + longint'($urandom_range(0, 2)) - 1;
                1: v = longint'($urandom_range(0, 50000));
                2: v = {$urandom, $urandom} & 64'h3FFF_FFFF_FFFF;
                default: v = {$urandom, $urandom} >> $urandom_range(18, 63);
            endcase
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1 chk("hold_out_data", bus.out_data, last_n);
            end
            run(v);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
